// File: rtl/fmap_pingpong_buf.sv
// Double-buffered feature-map store: NWR write ports fill one bank while rows, streams or points are read from the other.
// Latency: row read and each streamed row appear 1 cycle after issue; point read is combinational.
// Backpressure: none; rd_req/stream_start are ignored while a stream is active, swap is deferred until the stream ends.
module fmap_pingpong_buf #(
    parameter int DW   = 8,
    parameter int ROWS = 28,
    parameter int COLS = 7,
    parameter int NWR  = 4,
    parameter int AWR  = 5,
    parameter int AWC  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AWR-1:0]   wr_row,
    input  logic [NWR*AWC-1:0]   wr_col,
    input  logic [NWR*DW-1:0]    wr_data,
    input  logic                 swap,
    output logic                 swap_done,
    output logic                 wr_bank,
    input  logic                 rd_req,
    input  logic [AWR-1:0]       rd_row,
    input  logic                 stream_start,
    output logic                 stream_busy,
    output logic                 stream_done,
    output logic [COLS*DW-1:0]   rd_data,
    output logic [AWR-1:0]       rd_row_out,
    output logic                 rd_valid,
    input  logic                 pt_en,
    input  logic [AWR-1:0]       pt_row,
    input  logic [AWC-1:0]       pt_col,
    output logic [DW-1:0]        pt_data
);
    typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    localparam logic [AWR:0]   ROWS_W   = (AWR+1)'(ROWS);
    localparam logic [AWC:0]   COLS_W   = (AWC+1)'(COLS);
    localparam logic [AWR-1:0] LAST_ROW = AWR'(ROWS-1);

    state_t               state_q, state_d;
    logic [AWR-1:0]       cnt_q, cnt_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 swap_pending_q, swap_pending_d;
    logic                 swap_done_q, swap_done_d;
    logic [COLS*DW-1:0]   rd_data_q, rd_data_d;
    logic [AWR-1:0]       rd_row_out_q, rd_row_out_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 stream_busy_q, stream_busy_d;
    logic                 stream_done_q, stream_done_d;
    logic [DW-1:0]        mem_q [2][ROWS][COLS];
    logic [DW-1:0]        mem_d [2][ROWS][COLS];

    logic                 idle_free, start_acc, rd_acc, issue, issue_last;
    logic [AWR-1:0]       issue_row, sel_row;
    logic                 rd_bank;

    // Request qualification: the whole busy window (including the final row cycle) counts as not idle
    always_comb begin
        idle_free  = (state_q == S_IDLE) && !stream_busy_q;
        start_acc  = idle_free && stream_start;
        rd_acc     = idle_free && rd_req && !stream_start;
        issue      = start_acc || (state_q == S_STREAM);
        issue_row  = (state_q == S_STREAM) ? cnt_q + AWR'(1) : '0;
        issue_last = issue && (issue_row == LAST_ROW);
        rd_bank    = ~wr_bank_q;
        sel_row    = issue ? issue_row : rd_row;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: row 0 is issued on the start edge, so STREAM covers rows 1..ROWS-1
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_acc && !issue_last) state_d = S_STREAM;
            S_STREAM: if (issue_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: row read, stream flags, counter and bank swap bookkeeping
    always_comb begin
        cnt_d          = issue ? issue_row : cnt_q;
        rd_valid_d     = issue || rd_acc;
        stream_busy_d  = issue;
        stream_done_d  = issue_last;
        rd_data_d      = rd_data_q;
        rd_row_out_d   = rd_row_out_q;
        wr_bank_d      = wr_bank_q;
        swap_pending_d = swap_pending_q;
        swap_done_d    = 1'b0;
        if (rd_valid_d) begin
            rd_row_out_d = sel_row;
            rd_data_d    = '0;
            if ({1'b0, sel_row} < ROWS_W) begin
                for (int c = 0; c < COLS; c++) begin
                    rd_data_d[(COLS-1-c)*DW +: DW] = mem_q[rd_bank][sel_row][c];
                end
            end
        end
        // A swap arriving with an accepted stream start is deferred so the whole stream reads one bank
        if ((state_q == S_STREAM) || start_acc) begin
            if (swap) swap_pending_d = 1'b1;
        end else if (swap || swap_pending_q) begin
            wr_bank_d      = ~wr_bank_q;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
        end
    end

    // Write ports into the write bank; ascending loop lets the highest port win a collision
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && ({1'b0, wr_row[k*AWR +: AWR]} < ROWS_W)
                         && ({1'b0, wr_col[k*AWC +: AWC]} < COLS_W)) begin
                mem_d[wr_bank_q][wr_row[k*AWR +: AWR]][wr_col[k*AWC +: AWC]] = wr_data[k*DW +: DW];
            end
        end
    end

    // Datapath and memory registers, all cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q          <= '0;
            wr_bank_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            rd_data_q      <= '0;
            rd_row_out_q   <= '0;
            rd_valid_q     <= 1'b0;
            stream_busy_q  <= 1'b0;
            stream_done_q  <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        mem_q[b][r][c] <= '0;
        end else begin
            cnt_q          <= cnt_d;
            wr_bank_q      <= wr_bank_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            rd_data_q      <= rd_data_d;
            rd_row_out_q   <= rd_row_out_d;
            rd_valid_q     <= rd_valid_d;
            stream_busy_q  <= stream_busy_d;
            stream_done_q  <= stream_done_d;
            mem_q          <= mem_d;
        end
    end

    // Combinational point read from the read bank
    always_comb begin
        pt_data = '0;
        if (pt_en && ({1'b0, pt_row} < ROWS_W) && ({1'b0, pt_col} < COLS_W))
            pt_data = mem_q[rd_bank][pt_row][pt_col];
    end

    assign swap_done   = swap_done_q;
    assign wr_bank     = wr_bank_q;
    assign stream_busy = stream_busy_q;
    assign stream_done = stream_done_q;
    assign rd_data     = rd_data_q;
    assign rd_row_out  = rd_row_out_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: doc/fmap_pingpong_buf.md
Name: fmap_pingpong_buf

Overview:
- Parametrised, double-buffered (ping-pong) feature-map buffer: ROWS x COLS array of DW-bit words per bank, NWR independent write ports.
- Conv/pool stages write into the write bank while the next layer reads whole rows (registered) or single words from the read bank.
- Adds a row-streaming FSM, bank swap handshake and deterministic write-collision priority.

Parameters:
- DW, 8, data width per element
- ROWS, 28, rows per bank
- COLS, 7, columns per bank (one row read returns all COLS words)
- NWR, 4, number of write ports
- AWR, 5, row address width (2^AWR >= ROWS)
- AWC, 3, column address width (2^AWC >= COLS)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  NWR  per-port write enable
- wr_row  in  NWR*AWR  packed row addresses; port k at [k*AWR +: AWR]
- wr_col  in  NWR*AWC  packed column addresses
- wr_data  in  NWR*DW  packed write data
- swap  in  1  pulse: request bank exchange
- swap_done  out  1  one-cycle pulse when the exchange takes effect
- wr_bank  out  1  index of the current write bank (read bank = ~wr_bank)
- rd_req  in  1  single-row read request
- rd_row  in  AWR  row for rd_req
- stream_start  in  1  pulse: stream rows 0..ROWS-1 of the read bank
- stream_busy  out  1  high while streaming
- stream_done  out  1  one-cycle pulse with the last streamed row
- rd_data  out  COLS*DW  row data; col 0 in MSBs, col COLS-1 in LSBs
- rd_row_out  out  AWR  row index of the current rd_data
- rd_valid  out  1  rd_data / rd_row_out valid (one cycle)
- pt_en  in  1  point-read enable
- pt_row  in  AWR  point-read row
- pt_col  in  AWC  point-read column
- pt_data  out  DW  combinational point read from the read bank

Behaviour:
- Reset (async, low): both banks all zero; wr_bank=0; FSM IDLE; swap_pending=0; rd_data=0, rd_row_out=0, rd_valid=0, stream_busy=0, stream_done=0, swap_done=0.
- Writes:
  - Synchronous, always to bank wr_bank.
  - Port k writes when wr_en[k] and row<ROWS and col<COLS; out-of-range writes are dropped silently.
  - Collision (same row/col on several ports in one cycle): the highest port index wins.
  - Writes are accepted during streaming and during the swap cycle (they go to the pre-swap wr_bank).
- Swap:
  - In IDLE, swap toggles wr_bank at that clock edge; swap_done pulses the following cycle.
  - In STREAM, swap sets swap_pending; the toggle happens on the edge after the last streamed row, then swap_done pulses.
  - Multiple swaps while pending collapse into one.
- Row read (IDLE only):
  - rd_req at edge N -> rd_valid=1 in cycle N+1, with rd_data = read-bank row rd_row and rd_row_out = rd_row.
  - rd_row>=ROWS -> rd_valid=1, rd_data=0.
  - rd_req is ignored in STREAM and when stream_start is sampled in the same cycle (stream wins).
  - rd_data holds its last value when rd_valid=0.
- FSM IDLE -> STREAM:
  - On stream_start; the row counter loads 0.
  - Each STREAM cycle reads row cnt; rd_valid=1 on the next cycle; cnt increments.
  - After row ROWS-1 is issued, go to IDLE. stream_done coincides with the rd_valid of row ROWS-1.
  - stream_busy is high from the cycle after stream_start through the cycle stream_done is asserted.
  - stream_start while busy is ignored.
  - Stream latency: first row 1 cycle after start; ROWS consecutive rd_valid cycles.
- Point read: pt_data = read-bank[pt_row][pt_col] when pt_en and pt_row<ROWS and pt_col<COLS, else 0. Pure combinational; unaffected by FSM state.
- Read-during-swap: reads sampled on the swap edge use the pre-swap read bank.
- Reset mid-stream: immediate IDLE; outputs and memory cleared; pending swap discarded.

Test Plan:
- Reset, then 4 ports write (r,c)=(0,0..3) values 0x11..0x44; swap; rd_req row 0 -> next cycle rd_valid=1, rd_data=0x11223344_000000, rd_row_out=0.
- Ports 0 and 3 both write (5,2), values 0xAA/0xBB; swap; pt_en at (5,2) -> pt_data=0xBB; pt at (28,0) or (0,7) -> 0; writes to row 30 leave memory unchanged.
- Fill bank 0 with value = row*COLS+col; swap; stream_start -> 28 consecutive rd_valid with rd_row_out 0..27 and correct data; stream_done only with row 27; stream_busy spans exactly those cycles.
- swap pulsed at stream row 10 -> wr_bank unchanged until the stream ends, then toggles, swap_done pulses once; writes during the stream land in the old write bank.
- Ping-pong: write 0x01 pattern to bank 0, swap, write 0x02 pattern to bank 1 while streaming bank 0 -> all streamed data 0x01; swap; stream -> 0x02.
- Assert reset at stream row 15 -> rd_valid, stream_busy and wr_bank go to 0 immediately; a later point read returns 0 everywhere.
